// File: rtl/system_mode_controller.sv
// Sequences a serial-grid engine through load, generation-run and readout phases.
// One shared counter tracks bits or generations; DONE is registered so it lands on the first IDLE cycle.
module system_mode_controller #(
  parameter int DATA_SIZE = 64
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start_load,
  input  logic       i_run_req,
  input  logic [7:0] i_gen_count,
  input  logic       i_read_req,
  input  logic       i_abort,
  input  logic       i_serial_data_in,
  input  logic       i_serial_valid,
  input  logic       i_mem_serial_out,
  output logic       o_load_mode,
  output logic       o_run_mode,
  output logic       o_output_mode,
  output logic       o_serial_in,
  output logic       o_serial_data_out,
  output logic       o_out_valid,
  output logic       o_busy,
  output logic       o_done
);

  localparam int CNT_MAX = (DATA_SIZE > 255) ? DATA_SIZE : 255;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_OUTPUT} state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [7:0]    r_gen, w_gen_next;
  logic          r_done, w_done_next;
  logic          r_out_valid;
  logic [CW-1:0] w_gen_last;

  assign w_gen_last = CW'(r_gen) - CW'(1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_gen       <= '0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_gen       <= w_gen_next;
      r_done      <= w_done_next;
      r_out_valid <= o_output_mode;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_gen_next   = r_gen;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // ABORT in IDLE blocks every request that cycle
        if (!i_abort) begin
          if (i_start_load) begin
            w_state_next = S_LOAD;
            w_cnt_next   = '0;
          end else if (i_run_req) begin
            if (i_gen_count != 8'd0) begin
              w_state_next = S_RUN;
              w_gen_next   = i_gen_count;
              w_cnt_next   = '0;
            end else begin
              w_done_next = 1'b1;
            end
          end else if (i_read_req) begin
            w_state_next = S_OUTPUT;
            w_cnt_next   = '0;
          end
        end
      end
      S_LOAD: begin
        if (i_serial_valid) begin
          if (r_cnt == LAST_BIT) begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
            w_done_next  = 1'b1;
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
      end
      S_RUN: begin
        if (r_cnt == w_gen_last) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
          w_done_next  = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      S_OUTPUT: begin
        if (r_cnt == LAST_BIT) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
          w_done_next  = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
    if (i_abort && (r_state != S_IDLE)) begin
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
      w_done_next  = 1'b0;
    end
  end

  // Load shifts only on valid beats; run/output modes are pure state decodes
  assign o_load_mode       = (r_state == S_LOAD) && i_serial_valid;
  assign o_run_mode        = (r_state == S_RUN);
  assign o_output_mode     = (r_state == S_OUTPUT);
  assign o_serial_in       = i_serial_data_in;
  assign o_serial_data_out = i_mem_serial_out;
  assign o_out_valid       = r_out_valid;
  assign o_busy            = (r_state != S_IDLE);
  assign o_done            = r_done;

endmodule

// File: tb/tb_system_mode_controller.sv
// Randomized scoreboard bench: each stimulus cycle pushes the expected output vector,
// derived from the operation being issued; a negedge monitor pops and compares.
module tb_system_mode_controller;

  localparam int DS = 64;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_start_load = 1'b0, i_run_req = 1'b0, i_read_req = 1'b0, i_abort = 1'b0;
  logic [7:0] i_gen_count = 8'd0;
  logic       i_serial_data_in = 1'b0, i_serial_valid = 1'b0, i_mem_serial_out = 1'b0;
  logic       o_load_mode, o_run_mode, o_output_mode, o_serial_in, o_serial_data_out;
  logic       o_out_valid, o_busy, o_done;

  system_mode_controller #(.DATA_SIZE(DS)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start_load(i_start_load), .i_run_req(i_run_req),
    .i_gen_count(i_gen_count), .i_read_req(i_read_req), .i_abort(i_abort),
    .i_serial_data_in(i_serial_data_in), .i_serial_valid(i_serial_valid),
    .i_mem_serial_out(i_mem_serial_out), .o_load_mode(o_load_mode), .o_run_mode(o_run_mode),
    .o_output_mode(o_output_mode), .o_serial_in(o_serial_in),
    .o_serial_data_out(o_serial_data_out), .o_out_valid(o_out_valid), .o_busy(o_busy),
    .o_done(o_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic lm, rm, om, ov, busy, done, sin, sdo;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  logic prev_om = 1'b0;
  logic pend_done = 1'b0;

  task automatic chk(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0b expected=%0b t=%0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("load_mode", o_load_mode, mon_e.lm);
      chk("run_mode", o_run_mode, mon_e.rm);
      chk("output_mode", o_output_mode, mon_e.om);
      chk("out_valid", o_out_valid, mon_e.ov);
      chk("busy", o_busy, mon_e.busy);
      chk("done", o_done, mon_e.done);
      chk("serial_in", o_serial_in, mon_e.sin);
      chk("serial_data_out", o_serial_data_out, mon_e.sdo);
      chk("modes_exclusive",
          ($countones({o_load_mode, o_run_mode, o_output_mode}) <= 1), 1'b1);
    end
  end

  // One clock of stimulus: expected outputs follow from what the operation is doing this cycle
  task automatic cyc(input logic lm, input logic rm, input logic om, input logic busy);
    exp_t e;
    i_serial_data_in = 1'($urandom);
    i_mem_serial_out = 1'($urandom);
    e = '{lm: lm, rm: rm, om: om, ov: prev_om, busy: busy, done: pend_done,
          sin: i_serial_data_in, sdo: i_mem_serial_out};
    q.push_back(e);
    prev_om   = om;
    pend_done = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_req();
    i_start_load = 1'b0;
    i_run_req    = 1'b0;
    i_read_req   = 1'b0;
  endtask

  // Requests while busy must be ignored
  task automatic noise();
    i_start_load = ($urandom_range(0, 3) == 0);
    i_run_req    = ($urandom_range(0, 3) == 0);
    i_read_req   = ($urandom_range(0, 3) == 0);
    i_gen_count  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      i_serial_valid = 1'($urandom);
      cyc(0, 0, 0, 0);
    end
    i_serial_valid = 1'b0;
  endtask

  task automatic do_load(input bit gap3, input bit sim, input int abort_at);
    int   bits;
    int   c;
    logic v;
    i_start_load = 1'b1;
    if (sim) begin
      i_run_req   = 1'b1;
      i_read_req  = 1'b1;
      i_gen_count = 8'd7;
    end
    cyc(0, 0, 0, 0);
    clr_req();
    bits = 0;
    c = 0;
    while (bits < DS) begin
      v = gap3 ? (c % 3 != 2) : ($urandom_range(0, 2) != 0);
      i_serial_valid = v;
      noise();
      if (bits == abort_at) begin
        i_abort = 1'b1;
        cyc(v, 0, 0, 1);
        i_abort = 1'b0;
        i_serial_valid = 1'b0;
        clr_req();
        return;
      end
      cyc(v, 0, 0, 1);
      if (v) bits++;
      c++;
    end
    i_serial_valid = 1'b0;
    clr_req();
    pend_done = 1'b1;
  endtask

  task automatic do_run(input int n, input int abort_at);
    i_run_req   = 1'b1;
    i_gen_count = 8'(n);
    cyc(0, 0, 0, 0);
    clr_req();
    if (n == 0) begin
      pend_done = 1'b1;
      return;
    end
    for (int k = 0; k < n; k++) begin
      noise();
      if (k == abort_at) begin
        i_abort = 1'b1;
        cyc(0, 1, 0, 1);
        i_abort = 1'b0;
        clr_req();
        return;
      end
      cyc(0, 1, 0, 1);
    end
    clr_req();
    pend_done = 1'b1;
  endtask

  task automatic do_read(input int abort_at, input int reset_at);
    i_read_req = 1'b1;
    cyc(0, 0, 0, 0);
    clr_req();
    for (int k = 0; k < DS; k++) begin
      noise();
      if (k == reset_at) begin
        i_reset = 1'b1;
        i_abort = 1'b1;
        cyc(0, 0, 1, 1);
        i_reset = 1'b0;
        i_abort = 1'b0;
        prev_om = 1'b0;
        pend_done = 1'b0;
        clr_req();
        return;
      end
      if (k == abort_at) begin
        i_abort = 1'b1;
        cyc(0, 0, 1, 1);
        i_abort = 1'b0;
        clr_req();
        return;
      end
      cyc(0, 0, 1, 1);
    end
    clr_req();
    pend_done = 1'b1;
  endtask

  task automatic abort_idle();
    i_abort = 1'b1;
    i_start_load = 1'b1;
    i_run_req = 1'b1;
    i_read_req = 1'b1;
    i_gen_count = 8'd0;
    cyc(0, 0, 0, 0);
    i_abort = 1'b0;
    clr_req();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    cyc(0, 0, 0, 0);
    i_reset = 1'b0;
    idle(2);
    do_load(1'b1, 1'b0, -1);
    idle(2);
    do_run(5, -1);
    idle(1);
    do_run(0, -1);
    idle(2);
    do_read(-1, -1);
    idle(2);
    do_load(1'b0, 1'b1, -1);
    do_load(1'b0, 1'b0, 20);
    idle(2);
    do_read(-1, 30);
    idle(2);
    abort_idle();
    idle(2);
    do_run(255, -1);
    do_run(9, 4);
    idle(1);
    for (int i = 0; i < 40; i++) begin
      int n;
      int ab;
      case ($urandom_range(0, 4))
        0: begin
          ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DS - 1)) : -1;
          do_load(1'($urandom), 1'($urandom), ab);
        end
        1: begin
          n = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 30));
          ab = (n > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
          do_run(n, ab);
        end
        2: begin
          ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DS - 1)) : -1;
          do_read(ab, -1);
        end
        3: idle(int'($urandom_range(1, 4)));
        default: abort_idle();
      endcase
    end
    idle(3);
    @(negedge clk);
    #1;
    chk("queue_drained", (q.size() == 0), 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/system_mode_controller.md
SYSTEM_MODE_CONTROLLER -- requirements
Module: system_mode_controller

Interface
REQ-001 Parameter: data_size, default 64, grid bit count; number of serial bits per load/output transfer.
REQ-002 CLK  input  1  system clock; all state changes on rising edge; single clock domain.
REQ-003 RESET  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-004 START_LOAD  input  1  request serial load of one full grid.
REQ-005 RUN_REQ  input  1  request generation run.
REQ-006 GEN_COUNT  input  8  generations to run; sampled with RUN_REQ.
REQ-007 READ_REQ  input  1  request serial readout of current grid.
REQ-008 ABORT  input  1  cancel any active operation.
REQ-009 SERIAL_DATA_IN  input  1  external serial load bit.
REQ-010 SERIAL_VALID  input  1  SERIAL_DATA_IN valid this cycle.
REQ-011 MEM_SERIAL_OUT  input  1  serial bit from memory stage.
REQ-012 LOAD_MODE  output  1  memory load-shift enable.
REQ-013 RUN_MODE  output  1  memory capture-grid enable.
REQ-014 OUTPUT_MODE  output  1  memory shift-out enable.
REQ-015 SERIAL_IN  output  1  serial bit to memory.
REQ-016 SERIAL_DATA_OUT  output  1  external serial readout bit.
REQ-017 OUT_VALID  output  1  SERIAL_DATA_OUT valid this cycle.
REQ-018 BUSY  output  1  high whenever state is not IDLE.
REQ-019 DONE  output  1  one-cycle completion pulse.

Function
REQ-020 States SHALL be IDLE, LOAD, RUN, OUTPUT; encoding free.
REQ-021 In IDLE, requests SHALL be arbitrated with priority START_LOAD > RUN_REQ > READ_REQ; lower-priority simultaneous requests are dropped.
REQ-022 Requests in any state other than IDLE SHALL be ignored, not queued.
REQ-023 IDLE->LOAD on START_LOAD; bit counter cleared to 0.
REQ-024 In LOAD, LOAD_MODE SHALL equal SERIAL_VALID combinationally (memory shifts only on valid cycles); SERIAL_IN SHALL equal SERIAL_DATA_IN at all times.
REQ-025 LOAD counter SHALL increment on each SERIAL_VALID cycle; the cycle accepting bit data_size-1 SHALL transition to IDLE at the next edge.
REQ-026 IDLE->RUN on RUN_REQ with GEN_COUNT=N>0, N latched; RUN_MODE SHALL be high for exactly N consecutive cycles, then IDLE.
REQ-027 RUN_REQ with GEN_COUNT=0 SHALL stay in IDLE and pulse DONE the next cycle; RUN_MODE never asserted.
REQ-028 IDLE->OUTPUT on READ_REQ; OUTPUT_MODE SHALL be high for exactly data_size consecutive cycles, then IDLE.
REQ-029 RUN_MODE and OUTPUT_MODE SHALL be pure state decodes (no input dependence); at most one of LOAD_MODE/RUN_MODE/OUTPUT_MODE high in any cycle.
REQ-030 OUT_VALID SHALL be OUTPUT_MODE delayed one cycle (registered); SERIAL_DATA_OUT SHALL equal MEM_SERIAL_OUT, matching the memory's registered serial output.
REQ-031 DONE SHALL pulse high for one cycle, the first IDLE cycle after normal completion of LOAD, RUN or OUTPUT.
REQ-032 ABORT in any non-IDLE state SHALL force IDLE at next edge, all mode outputs low from that cycle, counters cleared, no DONE; ABORT in IDLE has priority over requests (none accepted).
REQ-033 Counters SHALL be sized to hold data_size and 255 without wrap; no wrap-around permitted.

Reset
REQ-034 On RESET: state IDLE, counters 0, LOAD_MODE/RUN_MODE/OUTPUT_MODE/OUT_VALID/DONE/BUSY = 0; RESET SHALL override ABORT and all requests, including mid-operation.

Verification
REQ-035 START_LOAD, then 64 bits with SERIAL_VALID gapped every 3rd cycle -> LOAD_MODE high exactly 64 cycles, DONE one cycle after last bit, BUSY low after.
REQ-036 RUN_REQ with GEN_COUNT=5 -> RUN_MODE high exactly 5 consecutive cycles starting next cycle, DONE on cycle 6; GEN_COUNT=0 -> no RUN_MODE, DONE next cycle.
REQ-037 READ_REQ -> OUTPUT_MODE high 64 cycles, OUT_VALID high 64 cycles lagging by one, SERIAL_DATA_OUT tracks MEM_SERIAL_OUT.
REQ-038 START_LOAD, RUN_REQ, READ_REQ same cycle in IDLE -> LOAD entered; RUN_REQ during LOAD ignored.
REQ-039 ABORT at bit 20 of LOAD, then RESET mid-OUTPUT -> mode outputs low next cycle, no DONE, IDLE.
